accum_bank: RTL and testbench
=============================

ACCUM_BANK -- requirements
Module: accum_bank

Interface
REQ-001 SHALL have parameter SIZE, default 8: number of channels (array columns).
REQ-002 SHALL have parameter DEPTH, default 8: number of accumulator rows per channel.
REQ-003 SHALL have parameter PSUM_WIDTH, default 45: signed width of each incoming partial sum.
REQ-004 SHALL have parameter ACC_WIDTH, default 48: signed width of each accumulator entry; ACC_WIDTH >= PSUM_WIDTH.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1: partial-sum vector present.
REQ-008 SHALL have port in_ready, output, 1: block accepts a write.
REQ-009 SHALL have port in_first, input, 1: 1 = load (overwrite), 0 = accumulate.
REQ-010 SHALL have port in_addr, input, clog2(DEPTH): target row.
REQ-011 SHALL have port in_psum, input, SIZE*PSUM_WIDTH: channel c in bits [c*PSUM_WIDTH +: PSUM_WIDTH].
REQ-012 SHALL have port drain_start, input, 1: pulse to begin draining all rows.
REQ-013 SHALL have port out_valid, output, 1: drained row present.
REQ-014 SHALL have port out_ready, input, 1: consumer accepts the drained row.
REQ-015 SHALL have port out_data, output, SIZE*ACC_WIDTH: drained row, packed like in_psum.
REQ-016 SHALL have port out_addr, output, clog2(DEPTH): index of the drained row.
REQ-017 SHALL have port ovf, output, SIZE: per-channel sticky saturation flags.

Function
REQ-018 SHALL implement FSM states IDLE and DRAIN; reset state is IDLE.
REQ-019 in_ready SHALL be 1 in IDLE and 0 in DRAIN; a write occurs on clk edge when in_valid && in_ready.
REQ-020 On write with in_first=1, row[in_addr][c] SHALL become the sign-extended in_psum[c].
REQ-021 On write with in_first=0, row[in_addr][c] SHALL become the saturated sum row[in_addr][c] + sign-extended in_psum[c].
REQ-022 Saturation SHALL clamp to +(2^(ACC_WIDTH-1))-1 or -(2^(ACC_WIDTH-1)) and set ovf[c]; ovf bits SHALL stay set until the next accepted drain_start.
REQ-023 A written value SHALL be readable by a drain beginning on the following cycle, giving 1-cycle write latency.
REQ-024 In IDLE, drain_start=1 SHALL move to DRAIN next cycle with drain pointer 0 and clear ovf; a simultaneous write SHALL complete first.
REQ-025 drain_start SHALL be ignored in DRAIN, and in_valid SHALL be ignored in DRAIN.
REQ-026 In DRAIN, out_valid SHALL be 1 and out_data/out_addr SHALL present the row at the pointer; both SHALL hold stable while out_ready=0.
REQ-027 On out_valid && out_ready, the drained row SHALL clear to 0 and the pointer SHALL increment; after row DEPTH-1 the FSM SHALL return to IDLE with out_valid=0 next cycle.
REQ-028 out_valid SHALL be 0 in IDLE; DEPTH beats with out_ready held 1 SHALL take exactly DEPTH cycles.

Reset
REQ-029 rst SHALL zero all rows, ovf, the drain pointer, out_valid and out_addr, and force IDLE, including mid-drain; rst SHALL take priority over every other input.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-031 A shared package SHALL hold the FSM state enum and the saturation limit constants derived from ACC_WIDTH.
REQ-032 Per-channel add/saturate SHALL be one sub-module, sat_add, instantiated SIZE times; row storage SHALL be a flop array.

Verification (SIZE=4, DEPTH=4, PSUM_WIDTH=16, ACC_WIDTH=20)
REQ-033 Write row 2 first={10,-5,0,7}, then accumulate {1,1,1,1}, then drain with out_ready=1 -> row 2 reads {11,-4,1,8}, rows 0/1/3 read 0, 4 beats in 4 cycles.
REQ-034 Drive 20 accumulates of 0x7FFF into channel 0 -> value clamps at 524287 and ovf[0]=1; other ovf bits stay 0; ovf clears on drain_start.
REQ-035 During drain, toggle out_ready 1,0,0,1 -> out_addr and out_data hold while ready=0, and no row is skipped or duplicated.
REQ-036 Raise in_valid and drain_start in the same cycle in IDLE (row 0 first=5) -> drain beat 0 shows 5; in_valid during DRAIN has no effect.
REQ-037 Assert rst at drain beat 1 -> out_valid=0 next cycle, IDLE, a later drain reads all zeros.
REQ-038 Drain twice back-to-back -> second drain reads all zeros.

Source files
------------

// File: rtl/accum_bank_pkg.sv
// rtl/accum_bank_pkg.sv - shared FSM state type and saturation limits for accum_bank
package accum_bank_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam int DEF_ACC_WIDTH = 48;

  // Limits are returned in a 64-bit container; callers size-cast to ACC_WIDTH.
  function automatic logic signed [63:0] acc_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] acc_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  localparam logic signed [DEF_ACC_WIDTH-1:0] DEF_ACC_MAX = DEF_ACC_WIDTH'(acc_max(DEF_ACC_WIDTH));
  localparam logic signed [DEF_ACC_WIDTH-1:0] DEF_ACC_MIN = DEF_ACC_WIDTH'(acc_min(DEF_ACC_WIDTH));

endpackage

// File: rtl/accum_bank_sat_add.sv
// rtl/accum_bank_sat_add.sv - one channel of load-or-accumulate with signed saturation
module sat_add
  import accum_bank_pkg::*;
#(
  parameter int PSUM_WIDTH = 45,
  parameter int ACC_WIDTH  = 48
) (
  input  logic [ACC_WIDTH-1:0]  acc,
  input  logic [PSUM_WIDTH-1:0] psum,
  input  logic                  first,
  output logic [ACC_WIDTH-1:0]  sum,
  output logic                  sat
);

  localparam logic [ACC_WIDTH-1:0] MAX_V = ACC_WIDTH'(acc_max(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] MIN_V = ACC_WIDTH'(acc_min(ACC_WIDTH));

  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH:0]   wide;

  assign ext  = ACC_WIDTH'($signed(psum));
  // One guard bit: overflow shows up as the top two bits disagreeing.
  assign wide = {acc[ACC_WIDTH-1], acc} + {ext[ACC_WIDTH-1], ext};

  always_comb begin
    sum = ext;
    sat = 1'b0;
    if (!first) begin
      if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
        sat = 1'b1;
        sum = wide[ACC_WIDTH] ? MIN_V : MAX_V;
      end else begin
        sum = wide[ACC_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/accum_bank.sv
// rtl/accum_bank.sv - banked row accumulator with saturating writes and a handshaked drain
module accum_bank
  import accum_bank_pkg::*;
#(
  parameter int SIZE       = 8,
  parameter int DEPTH      = 8,
  parameter int PSUM_WIDTH = 45,
  parameter int ACC_WIDTH  = 48
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_first,
  input  logic [$clog2(DEPTH)-1:0]   in_addr,
  input  logic [SIZE*PSUM_WIDTH-1:0] in_psum,
  input  logic                       drain_start,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SIZE*ACC_WIDTH-1:0]  out_data,
  output logic [$clog2(DEPTH)-1:0]   out_addr,
  output logic [SIZE-1:0]            ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t               state;
  logic [AW-1:0]        ptr;
  logic [ACC_WIDTH-1:0] rows [DEPTH][SIZE];
  logic [ACC_WIDTH-1:0] sum  [SIZE];
  logic [SIZE-1:0]      sat;

  for (genvar c = 0; c < SIZE; c++) begin : g_ch
    sat_add #(
      .PSUM_WIDTH (PSUM_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_sat_add (
      .acc   (rows[in_addr][c]),
      .psum  (in_psum[c*PSUM_WIDTH +: PSUM_WIDTH]),
      .first (in_first),
      .sum   (sum[c]),
      .sat   (sat[c])
    );
    assign out_data[c*ACC_WIDTH +: ACC_WIDTH] = rows[ptr][c];
  end

  assign out_addr = ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      ovf       <= '0;
      for (int r = 0; r < DEPTH; r++) begin
        for (int c = 0; c < SIZE; c++) begin
          rows[r][c] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int c = 0; c < SIZE; c++) begin
              rows[in_addr][c] <= sum[c];
            end
          end
          // A drain request starts a fresh overflow window, so it wins over a coincident saturation.
          if (drain_start) begin
            ovf       <= '0;
            ptr       <= '0;
            state     <= DRAIN;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
          end else if (in_valid) begin
            ovf <= ovf | sat;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            for (int c = 0; c < SIZE; c++) begin
              rows[ptr][c] <= '0;
            end
            if (ptr == LAST) begin
              ptr       <= '0;
              state     <= IDLE;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              ptr <= ptr + AW'(1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_bank.sv
// tb/tb_accum_bank.sv - randomized self-checking bench for accum_bank against a row/ovf model
module tb_accum_bank;

  localparam int SIZE = 4;
  localparam int DEPTH = 4;
  localparam int PW = 16;
  localparam int AW = 20;
  localparam longint MAXV = 524287;
  localparam longint MINV = -524288;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic           in_first;
  logic [1:0]     in_addr;
  logic [63:0]    in_psum;
  logic           drain_start;
  logic           out_valid;
  logic           out_ready;
  logic [79:0]    out_data;
  logic [1:0]     out_addr;
  logic [3:0]     ovf;

  int checks = 0;
  int failures = 0;

  longint   m_rows [DEPTH][SIZE];
  logic [3:0] m_ovf;

  accum_bank #(
    .SIZE       (SIZE),
    .DEPTH      (DEPTH),
    .PSUM_WIDTH (PW),
    .ACC_WIDTH  (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_first    (in_first),
    .in_addr     (in_addr),
    .in_psum     (in_psum),
    .drain_start (drain_start),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] vec4(input int a, input int b, input int c, input int d);
    logic [15:0] va, vb, vc, vd;
    va = 16'(a); vb = 16'(b); vc = 16'(c); vd = 16'(d);
    return {vd, vc, vb, va};
  endfunction

  function automatic logic [79:0] pack_row(input int r);
    logic [79:0] v;
    for (int c = 0; c < SIZE; c++) v[c*AW +: AW] = 20'(m_rows[r][c]);
    return v;
  endfunction

  function automatic void model_write(input bit first, input int addr, input logic [63:0] psv);
    longint e, s;
    logic [15:0] f;
    for (int c = 0; c < SIZE; c++) begin
      f = psv[c*PW +: PW];
      e = longint'($signed(f));
      if (first) s = e;
      else begin
        s = m_rows[addr][c] + e;
        if (s > MAXV) begin s = MAXV; m_ovf[c] = 1'b1; end
        if (s < MINV) begin s = MINV; m_ovf[c] = 1'b1; end
      end
      m_rows[addr][c] = s;
    end
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < DEPTH; r++)
      for (int c = 0; c < SIZE; c++) m_rows[r][c] = 0;
    m_ovf = '0;
  endfunction

  task automatic write_row(input bit first, input int addr, input logic [63:0] psv);
    @(negedge clk);
    in_valid = 1'b1; in_first = first; in_addr = addr[1:0]; in_psum = psv;
    @(negedge clk);
    in_valid = 1'b0;
    model_write(first, addr, psv);
    checks++;
    if (ovf !== m_ovf) begin
      failures++;
      $display("FAIL write_ovf addr=%0d got=%b exp=%b", addr, ovf, m_ovf);
    end
  endtask

  // Entered on the negedge where drain_start (and maybe a write) is being driven.
  task automatic run_drain(input int mode, input bit noise);
    int beat = 0;
    int cyc = 0;
    bit rdy;
    @(negedge clk);
    drain_start = 1'b0; in_valid = 1'b0;
    m_ovf = '0;
    checks++;
    if (ovf !== 4'b0) begin failures++; $display("FAIL drain_ovf_clear got=%b exp=0000", ovf); end
    while (beat < DEPTH && cyc < 64) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (noise) begin
        in_valid = 1'b1; in_first = 1'($urandom_range(0, 1));
        in_addr = 2'($urandom_range(0, 3)); in_psum = {$urandom, $urandom};
      end
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL drain_valid beat=%0d got=%b exp=1", beat, out_valid); end
      checks++;
      if (out_addr !== 2'(beat)) begin failures++; $display("FAIL drain_addr got=%0d exp=%0d", out_addr, beat); end
      checks++;
      if (out_data !== pack_row(beat)) begin
        failures++; $display("FAIL drain_data beat=%0d got=%h exp=%h", beat, out_data, pack_row(beat));
      end
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL drain_in_ready got=%b exp=0", in_ready); end
      @(negedge clk);
      cyc++;
      if (rdy) begin
        for (int c = 0; c < SIZE; c++) m_rows[beat][c] = 0;
        beat++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (beat != DEPTH) begin failures++; $display("FAIL drain_timeout beats=%0d exp=%0d", beat, DEPTH); end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL drain_end out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
    if (mode == 0) begin
      checks++;
      if (cyc != DEPTH) begin failures++; $display("FAIL drain_cycles got=%0d exp=%0d", cyc, DEPTH); end
    end
  endtask

  task automatic drain(input int mode, input bit noise);
    @(negedge clk);
    drain_start = 1'b1;
    run_drain(mode, noise);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (ovf !== 4'b0 || out_addr !== 2'b0) begin
      failures++; $display("FAIL reset_ovf_addr ovf=%b addr=%0d exp 0/0", ovf, out_addr);
    end
    checks++;
    if (out_data !== 80'b0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
  endtask

  task automatic test_basic();
    write_row(1'b1, 2, vec4(10, -5, 0, 7));
    write_row(1'b0, 2, vec4(1, 1, 1, 1));
    checks++;
    if (m_rows[2][0] != 11 || m_rows[2][1] != -4 || m_rows[2][2] != 1 || m_rows[2][3] != 8) begin
      failures++; $display("FAIL basic_model row2 got=%0d,%0d,%0d,%0d exp=11,-4,1,8",
        m_rows[2][0], m_rows[2][1], m_rows[2][2], m_rows[2][3]);
    end
    drain(0, 1'b0);
  endtask

  task automatic test_saturate();
    write_row(1'b1, 1, vec4(0, 0, 0, 0));
    for (int i = 0; i < 20; i++) write_row(1'b0, 1, vec4(32767, 0, 0, 0));
    checks++;
    if (ovf !== 4'b0001) begin failures++; $display("FAIL sat_ovf got=%b exp=0001", ovf); end
    checks++;
    if (m_rows[1][0] != MAXV) begin failures++; $display("FAIL sat_model got=%0d exp=%0d", m_rows[1][0], MAXV); end
    drain(0, 1'b0);
  endtask

  task automatic test_ready_toggle();
    for (int r = 0; r < DEPTH; r++) write_row(1'b1, r, {$urandom, $urandom});
    drain(1, 1'b0);
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    in_valid = 1'b1; in_first = 1'b1; in_addr = 2'd0; in_psum = vec4(5, 5, 5, 5);
    drain_start = 1'b1;
    model_write(1'b1, 0, vec4(5, 5, 5, 5));
    checks++;
    if (pack_row(0) !== {20'd5, 20'd5, 20'd5, 20'd5}) begin
      failures++; $display("FAIL simul_model got=%h", pack_row(0));
    end
    run_drain(2, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int a;
      a = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1)
        write_row(1'($urandom_range(0, 1)), a, {$urandom, $urandom});
      else
        write_row(1'b0, a, vec4(($urandom_range(0, 1) == 1) ? 32767 : -32768,
                               int'($urandom_range(0, 65535)), -32768, 32767));
    end
    drain(2, 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    for (int r = 0; r < DEPTH; r++) write_row(1'b1, r, {$urandom, $urandom});
    @(negedge clk);
    drain_start = 1'b1;
    @(negedge clk);
    drain_start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 2'd1) begin
      failures++; $display("FAIL midrst_beat1 valid=%b addr=%0d exp 1/1", out_valid, out_addr);
    end
    rst = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_addr !== 2'd0) begin
      failures++; $display("FAIL midrst_state valid=%b ready=%b addr=%0d exp 0/1/0", out_valid, in_ready, out_addr);
    end
    rst = 1'b0;
    model_clear();
    drain(0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < DEPTH; r++) write_row(1'b1, r, {$urandom, $urandom});
    drain(0, 1'b0);
    drain(0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_addr = '0; in_psum = '0;
    drain_start = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_saturate();
    test_ready_toggle();
    test_simultaneous();
    test_random();
    test_reset_mid_drain();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
